// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory/IO controller: memory-mapped device
// register addresses, device register indices and controller states.
package lc3_pkg;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  // Encoded to match the MDR input mux select; DDR is write-only so it shares 00 with RAM.
  typedef enum logic [1:0] {
    IO_DDR  = 2'b00,
    IO_KBSR = 2'b01,
    IO_KBDR = 2'b10,
    IO_DSR  = 2'b11
  } io_reg_e;

  typedef enum logic [2:0] {
    IDLE,
    RAM_ACC,
    RAM_WAIT,
    IO_ACC,
    DONE,
    LDR_WR
  } state_e;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU-side memory bus: request/direction/address/data from the CPU,
// ready and read data back from the controller.
interface mem_io_ctrl_if;
  logic        mio_en;
  logic        rw;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        r;
  logic [15:0] rdata;

  modport master (output mio_en, rw, mar, mdr, input  r, rdata);
  modport slave  (input  mio_en, rw, mar, mdr, output r, rdata);
endinterface

// File: rtl/lc3_addr_decode.sv
// Combinational decode of a 16-bit address into "is a device register" plus
// which device register it is.
module lc3_addr_decode
  import lc3_pkg::*;
(
  input  logic [15:0] addr,
  output logic        is_io,
  output io_reg_e     reg_idx
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    is_io   = 1'b1;
    reg_idx = IO_DDR;
    case (addr)
      ADDR_KBSR: reg_idx = IO_KBSR;
      ADDR_KBDR: reg_idx = IO_KBDR;
      ADDR_DSR:  reg_idx = IO_DSR;
      ADDR_DDR:  reg_idx = IO_DDR;
      default:   is_io   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// LC-3 memory/IO controller: arbitrates CPU and boot-loader requests, runs
// synchronous RAM accesses with programmable wait states and device-register strobes.
module mem_io_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          i_Clk,
  input  logic          reset_,
  mem_io_ctrl_if.slave  cpu,
  output logic [1:0]    inmux_sel,
  output logic          ld_kbsr,
  output logic          ld_dsr,
  output logic          ld_ddr,
  output logic          kbdr_rd,
  output logic          ram_en,
  output logic          ram_we,
  output logic [15:0]   ram_addr,
  output logic [15:0]   ram_wdata,
  input  logic [15:0]   ram_rdata,
  input  logic          ldr_req,
  input  logic [15:0]   ldr_addr,
  input  logic [15:0]   ldr_data,
  output logic          ldr_gnt
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e      state, state_nxt;
  logic        grant_cpu, grant_ldr;
  logic [15:0] dec_addr;
  logic        dec_is_io;
  io_reg_e     dec_reg;

  logic [15:0] addr_q, wdata_q, rdata_q;
  logic        rw_q, is_io_q, last_ldr_q, capture_q, done_first_q;
  io_reg_e     reg_q;
  logic [3:0]  wait_cnt;

  // Ties go to whichever requester did not win last; only IDLE arbitrates.
  always_comb begin
    grant_cpu = 1'b0;
    grant_ldr = 1'b0;
    if (state == IDLE) begin
      if (cpu.mio_en && ldr_req) begin
        grant_cpu = last_ldr_q;
        grant_ldr = !last_ldr_q;
      end else begin
        grant_cpu = cpu.mio_en;
        grant_ldr = ldr_req;
      end
    end
  end

  assign dec_addr = grant_ldr ? ldr_addr : cpu.mar;

  lc3_addr_decode u_decode (
    .addr    (dec_addr),
    .is_io   (dec_is_io),
    .reg_idx (dec_reg)
  );

  // DONE only exits on mio_en low, so a held request can never start a second access.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_cpu) state_nxt = dec_is_io ? IO_ACC : RAM_ACC;
                else if (grant_ldr) state_nxt = LDR_WR;
      RAM_ACC:  state_nxt = (WAIT_CYCLES == 0) ? DONE : RAM_WAIT;
      RAM_WAIT: if (wait_cnt == 4'd0) state_nxt = DONE;
      IO_ACC:   state_nxt = DONE;
      DONE:     if (!cpu.mio_en) state_nxt = IDLE;
      LDR_WR:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu.r     = 1'b0;
    inmux_sel = 2'b00;
    ld_kbsr   = 1'b0;
    ld_dsr    = 1'b0;
    ld_ddr    = 1'b0;
    kbdr_rd   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 16'h0000;
    ram_wdata = 16'h0000;
    ldr_gnt   = 1'b0;
    case (state)
      RAM_ACC: begin
        ram_en    = 1'b1;
        ram_we    = rw_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
      end
      IO_ACC: begin
        inmux_sel = reg_q;
        ld_kbsr   = rw_q && (reg_q == IO_KBSR);
        ld_dsr    = rw_q && (reg_q == IO_DSR);
        ld_ddr    = rw_q && (reg_q == IO_DDR);
      end
      DONE: begin
        cpu.r     = 1'b1;
        inmux_sel = is_io_q ? reg_q : 2'b00;
        kbdr_rd   = done_first_q && is_io_q && !rw_q && (reg_q == IO_KBDR);
      end
      LDR_WR: begin
        // Loader writes aimed at device registers are acknowledged but never reach RAM.
        ldr_gnt   = 1'b1;
        ram_en    = !is_io_q;
        ram_we    = !is_io_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // Synchronous RAM data is valid only in the cycle after RAM_ACC: pass it through then, hold it after.
  assign cpu.rdata = capture_q ? ram_rdata : rdata_q;

  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      state        <= IDLE;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      rdata_q      <= 16'h0000;
      rw_q         <= 1'b0;
      is_io_q      <= 1'b0;
      reg_q        <= IO_DDR;
      last_ldr_q   <= 1'b1;
      capture_q    <= 1'b0;
      done_first_q <= 1'b0;
      wait_cnt     <= 4'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state        <= state_nxt;
      done_first_q <= (state_nxt == DONE) && (state != DONE);
      capture_q    <= (state == RAM_ACC) && !rw_q;
      if (capture_q) rdata_q <= ram_rdata;

      if (grant_cpu) begin
        addr_q     <= cpu.mar;
        wdata_q    <= cpu.mdr;
        rw_q       <= cpu.rw;
        last_ldr_q <= 1'b0;
      end else if (grant_ldr) begin
        addr_q     <= ldr_addr;
        wdata_q    <= ldr_data;
        rw_q       <= 1'b1;
        last_ldr_q <= 1'b1;
      end
      if (grant_cpu || grant_ldr) begin
        is_io_q <= dec_is_io;
        reg_q   <= dec_reg;
      end

      if (state == RAM_ACC) wait_cnt <= WAIT_LOAD;
      else if (state == RAM_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: directed CPU/loader traffic pushes expected
// completions, RAM ops, strobes and grants; one monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_io_ctrl;
  import lc3_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (WAIT_CYCLES = 2) ----------------
  mem_io_ctrl_if bus ();
  logic [1:0]  inmux_sel;
  logic        ld_kbsr, ld_dsr, ld_ddr, kbdr_rd, ram_en, ram_we, ldr_req, ldr_gnt;
  logic [15:0] ram_addr, ram_wdata, ram_rdata, ldr_addr, ldr_data;

  mem_io_ctrl #(.WAIT_CYCLES(2)) dut (
    .i_Clk(clk), .reset_(reset_), .cpu(bus), .inmux_sel(inmux_sel),
    .ld_kbsr(ld_kbsr), .ld_dsr(ld_dsr), .ld_ddr(ld_ddr), .kbdr_rd(kbdr_rd),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
    .ldr_gnt(ldr_gnt)
  );

  logic [15:0] pre_mem [0:65535];
  logic [15:0] mem     [0:65535];
  logic        written [0:65535];
  initial ram_rdata = 16'h0000;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : pre_mem[ram_addr];
      end
    end
  end

  // ---------------- second DUT (WAIT_CYCLES = 0) ----------------
  mem_io_ctrl_if bus0 ();
  logic [1:0]  inmux_sel0;
  logic        ld_kbsr0, ld_dsr0, ld_ddr0, kbdr_rd0, ram_en0, ram_we0, ldr_gnt0;
  logic        ldr_req0 = 1'b0;
  logic [15:0] ldr_addr0 = 16'h0000, ldr_data0 = 16'h0000;
  logic [15:0] ram_addr0, ram_wdata0, ram_rdata0;
  int          ram0_cnt = 0;

  mem_io_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .i_Clk(clk), .reset_(reset_), .cpu(bus0), .inmux_sel(inmux_sel0),
    .ld_kbsr(ld_kbsr0), .ld_dsr(ld_dsr0), .ld_ddr(ld_ddr0), .kbdr_rd(kbdr_rd0),
    .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
    .ram_rdata(ram_rdata0), .ldr_req(ldr_req0), .ldr_addr(ldr_addr0), .ldr_data(ldr_data0),
    .ldr_gnt(ldr_gnt0)
  );

  initial ram_rdata0 = 16'h0000;
  always @(posedge clk) begin
    if (ram_en0) begin
      ram0_cnt <= ram0_cnt + 1;
      if (!ram_we0) ram_rdata0 <= ram_addr0 ^ 16'h5A5A;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [15:0] rdata; logic chk_rdata; logic [1:0] inmux; int start; int lat; } resp_t;
  typedef struct { logic [15:0] addr; logic we; logic [15:0] data; } ramop_t;
  typedef struct { logic [15:0] addr; logic en; } gnt_t;

  resp_t      resp_q[$];
  ramop_t     ram_q[$];
  logic [3:0] strb_q[$];
  gnt_t       gnt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  resp_t      er;
  ramop_t     eo;
  gnt_t       eg;
  logic [3:0] es;
  logic [3:0] strb_now;
  logic       r_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reset_) begin
      if (bus.r && !r_prev) begin
        if (resp_q.size() == 0) check("unexpected_r", 32'(bus.r), 32'(0));
        else begin
          er = resp_q.pop_front();
          if (er.lat >= 0) check("latency", 32'(cyc - er.start), 32'(er.lat));
          check("inmux_done", 32'(inmux_sel), 32'(er.inmux));
          if (er.chk_rdata) check("rdata", 32'(bus.rdata), 32'(er.rdata));
        end
      end
      if (ram_en) begin
        if (ram_q.size() == 0) check("unexpected_ram_en", 32'(ram_en), 32'(0));
        else begin
          eo = ram_q.pop_front();
          check("ram_addr", 32'(ram_addr), 32'(eo.addr));
          check("ram_we", 32'(ram_we), 32'(eo.we));
          if (eo.we) check("ram_wdata", 32'(ram_wdata), 32'(eo.data));
        end
      end
      strb_now = {kbdr_rd, ld_ddr, ld_dsr, ld_kbsr};
      if (strb_now != 4'b0000) begin
        if (strb_q.size() == 0) check("unexpected_strobe", 32'(strb_now), 32'(0));
        else begin
          es = strb_q.pop_front();
          check("strobe", 32'(strb_now), 32'(es));
        end
      end
      if (ldr_gnt) begin
        if (gnt_q.size() == 0) check("unexpected_ldr_gnt", 32'(ldr_gnt), 32'(0));
        else begin
          eg = gnt_q.pop_front();
          check("gnt_addr", 32'(ram_addr), 32'(eg.addr));
          check("gnt_ram_en", 32'(ram_en), 32'(eg.en));
        end
      end
    end
    r_prev <= bus.r;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_r(input string nm, input int budget);
    int n = 0;
    while (!bus.r && n < budget) begin @(posedge clk); #1; n++; end
    if (!bus.r) check(nm, 32'(bus.r), 32'(1));
  endtask

  task automatic finish_cpu(input int hold);
    wait_r("r_timeout", 30);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("r_held", 32'(bus.r), 32'(1));
      check("no_gnt_in_done", 32'(ldr_gnt), 32'(0));
    end
    @(negedge clk);
    bus.mio_en = 1'b0;
    @(posedge clk); #1;
    check("r_release", 32'(bus.r), 32'(0));
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    while (!ldr_gnt && n < budget) begin @(posedge clk); #1; n++; end
    if (!ldr_gnt) check("gnt_timeout", 32'(ldr_gnt), 32'(1));
    @(negedge clk);
    ldr_req = 1'b0;
  endtask

  typedef struct {
    logic w; logic [15:0] a; logic [15:0] d; logic pre; logic [15:0] rv;
    logic [1:0] inmux; logic [3:0] strb; logic is_ram; int lat;
  } vec_t;
  vec_t vt [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int n;
    //            w     addr      wdata     pre   rdata     inmux  strobe   ram   lat
    vt[0]  = '{1'b0, 16'h3000, 16'h0000, 1'b1, 16'h1234, 2'b00, 4'b0000, 1'b1, 4};
    vt[1]  = '{1'b1, 16'hFE06, 16'h0041, 1'b0, 16'h0000, 2'b00, 4'b0100, 1'b0, 2};
    vt[2]  = '{1'b0, 16'hFE02, 16'h0000, 1'b0, 16'h0000, 2'b10, 4'b1000, 1'b0, 2};
    vt[3]  = '{1'b1, 16'hFE00, 16'h8000, 1'b0, 16'h0000, 2'b01, 4'b0001, 1'b0, 2};
    vt[4]  = '{1'b1, 16'hFE04, 16'h0000, 1'b0, 16'h0000, 2'b11, 4'b0010, 1'b0, 2};
    vt[5]  = '{1'b1, 16'hFE02, 16'h0055, 1'b0, 16'h0000, 2'b10, 4'b0000, 1'b0, 2};
    vt[6]  = '{1'b0, 16'hFE00, 16'h0000, 1'b0, 16'h0000, 2'b01, 4'b0000, 1'b0, 2};
    vt[7]  = '{1'b1, 16'h3001, 16'hBEEF, 1'b0, 16'h0000, 2'b00, 4'b0000, 1'b1, 4};
    vt[8]  = '{1'b0, 16'h3001, 16'h0000, 1'b0, 16'hBEEF, 2'b00, 4'b0000, 1'b1, 4};
    vt[9]  = '{1'b0, 16'hFE01, 16'h0000, 1'b1, 16'h0F0F, 2'b00, 4'b0000, 1'b1, 4};
    vt[10] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h7777, 2'b00, 4'b0000, 1'b1, 4};
    vt[11] = '{1'b0, 16'hFE08, 16'h0000, 1'b1, 16'h1111, 2'b00, 4'b0000, 1'b1, 4};

    for (int i = 0; i < 65536; i++) pre_mem[i] = 16'hDEAD;
    for (int i = 0; i < 12; i++) if (vt[i].pre) pre_mem[vt[i].a] = vt[i].rv;

    reset_ = 1'b0;
    bus.mio_en = 1'b0; bus.rw = 1'b0; bus.mar = 16'h0000; bus.mdr = 16'h0000;
    bus0.mio_en = 1'b0; bus0.rw = 1'b0; bus0.mar = 16'h0000; bus0.mdr = 16'h0000;
    ldr_req = 1'b0; ldr_addr = 16'h0000; ldr_data = 16'h0000;

    // Reset state
    #2;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_r", 32'(bus.r), 32'(0));
    check("rst_rdata", 32'(bus.rdata), 32'(0));
    check("rst_ram_en", 32'(ram_en), 32'(0));
    check("rst_outs", 32'({inmux_sel, ld_kbsr, ld_dsr, ld_ddr, kbdr_rd, ram_we, ldr_gnt}), 32'(0));
    check("rst_r0", 32'(bus0.r), 32'(0));
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);

    // Directed CPU accesses
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.mio_en = 1'b1; bus.rw = vt[i].w; bus.mar = vt[i].a; bus.mdr = vt[i].d;
      resp_q.push_back('{vt[i].rv, vt[i].is_ram && !vt[i].w, vt[i].inmux, cyc, vt[i].lat});
      if (vt[i].is_ram) ram_q.push_back('{vt[i].a, vt[i].w, vt[i].d});
      if (vt[i].strb != 4'b0000) strb_q.push_back(vt[i].strb);
      finish_cpu(2);
    end

    // Tie after a CPU grant: loader wins, CPU reads back the loader's data
    @(negedge clk);
    bus.mio_en = 1'b1; bus.rw = 1'b0; bus.mar = 16'h4002;
    ldr_req = 1'b1; ldr_addr = 16'h4002; ldr_data = 16'hCCCC;
    gnt_q.push_back('{16'h4002, 1'b1});
    ram_q.push_back('{16'h4002, 1'b1, 16'hCCCC});
    ram_q.push_back('{16'h4002, 1'b0, 16'h0000});
    resp_q.push_back('{16'hCCCC, 1'b1, 2'b00, cyc, -1});
    wait_gnt(20);
    finish_cpu(1);

    // Loader alone, I/O address: granted but dropped
    @(negedge clk);
    ldr_req = 1'b1; ldr_addr = 16'hFE06; ldr_data = 16'h1111;
    gnt_q.push_back('{16'hFE06, 1'b0});
    wait_gnt(20);
    @(negedge clk);

    // Simultaneous requests twice after a loader grant: CPU then loader each time
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.mio_en = 1'b1; bus.rw = 1'b0; bus.mar = 16'h3000;
      ldr_req = 1'b1; ldr_addr = (k == 0) ? 16'h4000 : 16'h4001; ldr_data = (k == 0) ? 16'hAAAA : 16'hBBBB;
      resp_q.push_back('{16'h1234, 1'b1, 2'b00, cyc, 4});
      ram_q.push_back('{16'h3000, 1'b0, 16'h0000});
      ram_q.push_back('{ldr_addr, 1'b1, ldr_data});
      gnt_q.push_back('{ldr_addr, 1'b1});
      finish_cpu(2);
      wait_gnt(20);
      @(negedge clk);
    end

    // Reset during RAM_WAIT of a write
    @(negedge clk);
    bus.mio_en = 1'b1; bus.rw = 1'b1; bus.mar = 16'h3100; bus.mdr = 16'h5555;
    ram_q.push_back('{16'h3100, 1'b1, 16'h5555});
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_ = 1'b0;
    #1;
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_r", 32'(bus.r), 32'(0));
    check("mid_rst_ram_en", 32'(ram_en), 32'(0));
    check("mid_rst_rdata", 32'(bus.rdata), 32'(0));
    check("mid_rst_outs", 32'({inmux_sel, ld_kbsr, ld_dsr, ld_ddr, kbdr_rd, ram_we, ldr_gnt}), 32'(0));
    bus.mio_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_r", 32'(bus.r), 32'(0));

    // WAIT_CYCLES = 0 instance: latency 2, held request does not repeat
    @(negedge clk);
    bus0.mio_en = 1'b1; bus0.rw = 1'b0; bus0.mar = 16'h2000;
    st = cyc; n = 0;
    while (!bus0.r && n < 20) begin @(posedge clk); #1; n++; end
    check("w0_latency", 32'(cyc - st), 32'(2));
    check("w0_rdata", 32'(bus0.rdata), 32'h7A5A);
    check("w0_inmux", 32'(inmux_sel0), 32'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("w0_r_held", 32'(bus0.r), 32'(1));
      check("w0_no_ram_en", 32'(ram_en0), 32'(0));
    end
    @(negedge clk);
    bus0.mio_en = 1'b0;
    @(negedge clk);
    check("w0_r_release", 32'(bus0.r), 32'(0));
    bus0.mio_en = 1'b1; bus0.mar = 16'h2001;
    st = cyc; n = 0;
    while (!bus0.r && n < 20) begin @(posedge clk); #1; n++; end
    check("w0_latency2", 32'(cyc - st), 32'(2));
    check("w0_rdata2", 32'(bus0.rdata), 32'h7A5B);
    @(negedge clk);
    bus0.mio_en = 1'b0;
    repeat (3) @(negedge clk);
    check("w0_ram_accesses", 32'(ram0_cnt), 32'(2));

    repeat (2) @(negedge clk);
    check("resp_q_empty", 32'(resp_q.size()), 32'(0));
    check("ram_q_empty", 32'(ram_q.size()), 32'(0));
    check("strb_q_empty", 32'(strb_q.size()), 32'(0));
    check("gnt_q_empty", 32'(gnt_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
